// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
// Segment codes are active-high {dp,g,f,e,d,c,b,a}; polarity is applied at the top level.
package seg_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    function automatic int calc_scan_div(input int clk_freq, input int scan_hz);
        return clk_freq / scan_hz;
    endfunction

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational BCD nibble + decimal point to active-high segment pattern.
module seg_bcd_decode (
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);
    import seg_scan_driver_pkg::*;

    logic [6:0] glyph_s;

    // Glyph lookup; nibbles A-F render as a dash so bad data is visible
    always_comb begin
        glyph_s = SEG_DASH[6:0];
        case (nibble)
            4'd0:    glyph_s = SEG_0[6:0];
            4'd1:    glyph_s = SEG_1[6:0];
            4'd2:    glyph_s = SEG_2[6:0];
            4'd3:    glyph_s = SEG_3[6:0];
            4'd4:    glyph_s = SEG_4[6:0];
            4'd5:    glyph_s = SEG_5[6:0];
            4'd6:    glyph_s = SEG_6[6:0];
            4'd7:    glyph_s = SEG_7[6:0];
            4'd8:    glyph_s = SEG_8[6:0];
            4'd9:    glyph_s = SEG_9[6:0];
            default: glyph_s = SEG_DASH[6:0];
        endcase
    end

    assign pattern = {dp, glyph_s};

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with guard time, leading-zero
// blanking and a per-frame snapshot of the display word.
module seg_scan_driver #(
    parameter int CLK_FREQ       = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int GUARD          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        en,
    input  logic        blank_lz,
    input  logic [15:0] dis_data,
    input  logic [3:0]  dis_point,
    output logic [3:0]  seg_sel,
    output logic [7:0]  seg_led
);
    import seg_scan_driver_pkg::*;

    localparam int SCAN_DIV = calc_scan_div(CLK_FREQ, SCAN_HZ);
    localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W    = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [3:0] SEL_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0] LED_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    generate
        if (SCAN_DIV < GUARD + 2) begin : g_bad_scan_params
            $error("seg_scan_driver: SCAN_DIV must be at least GUARD+2");
        end
    endgenerate

    scan_state_e      state_r, nxt_state_s;
    logic [CNT_W-1:0] cnt_r, nxt_cnt_s;
    logic [DIG_W-1:0] dig_r, nxt_dig_s;
    logic [15:0]      snap_data_r;
    logic [3:0]       snap_point_r;
    logic             snap_load_s;
    logic             show_s;
    logic [3:0]       nib_s;
    logic             dp_s;
    logic [7:0]       pattern_s;
    logic [7:0]       raw_s;
    logic [3:0]       zero_s;
    logic [3:0]       lz_blank_s;
    logic [3:0]       onehot_s;
    logic [3:0]       sel_s;
    logic [7:0]       led_s;
    logic [3:0]       seg_sel_r;
    logic [7:0]       seg_led_r;

    // Scan state, slot counter and digit index
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_r <= ST_OFF;
            cnt_r   <= CNT_ZERO;
            dig_r   <= {DIG_W{1'b0}};
        end else begin
            state_r <= nxt_state_s;
            cnt_r   <= nxt_cnt_s;
            dig_r   <= nxt_dig_s;
        end
    end

    // Advance the slot counter; disabling parks everything at slot 0, digit 0
    always_comb begin
        nxt_state_s = ST_OFF;
        nxt_cnt_s   = CNT_ZERO;
        nxt_dig_s   = {DIG_W{1'b0}};
        if (en) begin
            if (cnt_r == CNT_LAST) begin
                nxt_cnt_s = CNT_ZERO;
                nxt_dig_s = dig_r + DIG_W'(1);
            end else begin
                nxt_cnt_s = cnt_r + CNT_W'(1);
                nxt_dig_s = dig_r;
            end
            if (nxt_cnt_s < CNT_GUARD) begin
                nxt_state_s = ST_GUARD;
            end else begin
                nxt_state_s = ST_SHOW;
            end
        end else begin
            nxt_state_s = ST_OFF;
        end
    end

    // Digit is lit only in SHOW with en still high; ST_OFF is slot 0 of a fresh start
    always_comb begin
        show_s = 1'b0;
        case (state_r)
            ST_OFF:   show_s = en && (CNT_GUARD == CNT_ZERO);
            ST_GUARD: show_s = 1'b0;
            ST_SHOW:  show_s = en;
            default:  show_s = 1'b0;
        endcase
    end

    assign snap_load_s = en && (cnt_r == CNT_ZERO) && (dig_r == {DIG_W{1'b0}});

    // Frame-coherent capture of the display word at each frame start
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            snap_data_r  <= 16'h0000;
            snap_point_r <= 4'h0;
        end else if (snap_load_s) begin
            snap_data_r  <= dis_data;
            snap_point_r <= dis_point;
        end
    end

    assign nib_s = snap_data_r[{dig_r, 2'b00} +: 4];
    assign dp_s  = snap_point_r[dig_r];

    seg_bcd_decode u_decode (
        .nibble  (nib_s),
        .dp      (dp_s),
        .pattern (pattern_s)
    );

    // A digit is a leading zero only if it and every digit to its left are 0 without a DP
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_s[i] = (snap_data_r[i*4 +: 4] == 4'h0) && !snap_point_r[i];
        end
        lz_blank_s[3] = zero_s[3];
        lz_blank_s[2] = zero_s[3] && zero_s[2];
        lz_blank_s[1] = zero_s[3] && zero_s[2] && zero_s[1];
        lz_blank_s[0] = 1'b0;
    end

    assign onehot_s = 4'b0001 << dig_r;

    // Next output values; blanked digits keep their select for uniform duty
    always_comb begin
        raw_s = SEG_OFF;
        sel_s = SEL_OFF;
        led_s = LED_OFF;
        if (show_s) begin
            if (blank_lz && lz_blank_s[dig_r]) begin
                raw_s = SEG_OFF;
            end else begin
                raw_s = pattern_s;
            end
            sel_s = DIG_ACTIVE_LOW ? ~onehot_s : onehot_s;
            led_s = SEG_ACTIVE_LOW ? ~raw_s : raw_s;
        end else begin
            raw_s = SEG_OFF;
            sel_s = SEL_OFF;
            led_s = LED_OFF;
        end
    end

    // Registered pad drivers
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            seg_sel_r <= SEL_OFF;
            seg_led_r <= LED_OFF;
        end else begin
            seg_sel_r <= sel_s;
            seg_led_r <= led_s;
        end
    end

    assign seg_sel = seg_sel_r;
    assign seg_led = seg_led_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: SCAN_DIV=10, GUARD=2, 40-cycle frames.
// Expected outputs are keyed by clock-edge number and checked by a negedge monitor.
module tb_seg_scan_driver;

    localparam int GUARD    = 2;
    localparam int SCAN_DIV = 10;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        en;
    logic        blank_lz;
    logic [15:0] dis_data;
    logic [3:0]  dis_point;
    logic [3:0]  seg_sel;
    logic [7:0]  seg_led;
    logic [3:0]  seg_sel_ah;
    logic [7:0]  seg_led_ah;

    always #5 sys_clk = ~sys_clk;

    seg_scan_driver #(
        .CLK_FREQ(1000), .SCAN_HZ(100), .GUARD(GUARD),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .en(en), .blank_lz(blank_lz),
        .dis_data(dis_data), .dis_point(dis_point), .seg_sel(seg_sel), .seg_led(seg_led)
    );

    seg_scan_driver #(
        .CLK_FREQ(1000), .SCAN_HZ(100), .GUARD(GUARD),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
    ) dut_ah (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .en(en), .blank_lz(blank_lz),
        .dis_data(dis_data), .dis_point(dis_point), .seg_sel(seg_sel_ah), .seg_led(seg_led_ah)
    );

    typedef struct packed {
        int         cyc;
        logic [3:0] sel;
        logic [7:0] led;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   k;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int at, input logic [11:0] act, input logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s edge=%0d actual=%h required=%h", tag, at, act, req);
        end
    endtask

    // Monitor: compare every expectation whose edge has been reached
    always @(negedge sys_clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.cyc < cyc) begin
                check("late_entry", mon_e.cyc, 12'(cyc), 12'(mon_e.cyc));
            end else begin
                check("sel", cyc, {8'h00, seg_sel}, {8'h00, mon_e.sel});
                check("led", cyc, {4'h0, seg_led}, {4'h0, mon_e.led});
                check("sel_ah", cyc, {8'h00, seg_sel_ah}, {8'h00, mon_e.sel});
                check("led_ah", cyc, {4'h0, seg_led_ah}, {4'h0, ~mon_e.led});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push_off(input int from, input int n);
        for (int i = 0; i < n; i++) q.push_back('{from + i, 4'hF, 8'hFF});
    endtask

    // Active-low expectations for one frame (l0 = rightmost digit), first n edges
    task automatic push_frame(input int start, input int n, input logic [7:0] l0,
                              input logic [7:0] l1, input logic [7:0] l2, input logic [7:0] l3);
        logic [7:0] leds [4];
        logic [3:0] s;
        leds[0] = l0; leds[1] = l1; leds[2] = l2; leds[3] = l3;
        for (int i = 0; i < n; i++) begin
            if ((i % SCAN_DIV) < GUARD) begin
                q.push_back('{start + i, 4'hF, 8'hFF});
            end else begin
                s = 4'b0001 << (i / SCAN_DIV);
                q.push_back('{start + i, ~s, leds[i / SCAN_DIV]});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog edge=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        sys_reset = 1'b1; en = 1'b0; blank_lz = 1'b0; dis_data = 16'h0000; dis_point = 4'h0;
        push_off(cyc + 1, 3);
        step(3);
        sys_reset = 1'b0;
        push_off(cyc + 1, 3);
        step(3);

        // 1234, no blanking: digit0=4, 1=3, 2=2, 3=1; two frames
        dis_data = 16'h1234; en = 1'b1; k = cyc;
        push_frame(k + 1, 40, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        push_frame(k + 41, 40, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        step(80);

        // 0012 with DP on digit2, blanking on: digit3 blanked, digit2 shows 0.
        dis_data = 16'h0012; dis_point = 4'b0100; blank_lz = 1'b1; k = cyc;
        push_frame(k + 1, 40, 8'hA4, 8'hF9, 8'h40, 8'hFF);
        step(40);
        blank_lz = 1'b0; k = cyc;
        push_frame(k + 1, 40, 8'hA4, 8'hF9, 8'h40, 8'hC0);
        step(40);

        // 000A blanked: only the dash on digit0
        dis_data = 16'h000A; dis_point = 4'h0; blank_lz = 1'b1; k = cyc;
        push_frame(k + 1, 40, 8'hBF, 8'hFF, 8'hFF, 8'hFF);
        step(40);

        // Mid-frame input change must not tear the frame
        dis_data = 16'h1111; blank_lz = 1'b0; k = cyc;
        push_frame(k + 1, 40, 8'hF9, 8'hF9, 8'hF9, 8'hF9);
        push_frame(k + 41, 40, 8'hA4, 8'hA4, 8'hA4, 8'hA4);
        step(15);
        dis_data = 16'h2222;
        step(65);

        // 8888: active-low 80, active-high instance 7F
        dis_data = 16'h8888; k = cyc;
        push_frame(k + 1, 40, 8'h80, 8'h80, 8'h80, 8'h80);
        step(40);

        // Disable mid-frame for 25 cycles, re-enable with fresh data
        dis_data = 16'h1234; k = cyc;
        push_frame(k + 1, 15, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        step(15);
        en = 1'b0; dis_data = 16'h5678;
        push_off(k + 16, 25);
        step(25);
        en = 1'b1; k = cyc;
        push_frame(k + 1, 40, 8'h80, 8'hF8, 8'h82, 8'h92);
        step(40);

        // Asynchronous reset between edges during digit2 SHOW
        k = cyc;
        push_frame(k + 1, 23, 8'h80, 8'hF8, 8'h82, 8'h92);
        step(23);
        #6;
        sys_reset = 1'b1;
        #1;
        check("async_rst_sel", cyc, {8'h00, seg_sel}, 12'h00F);
        check("async_rst_led", cyc, {4'h0, seg_led}, 12'h0FF);
        check("async_rst_led_ah", cyc, {4'h0, seg_led_ah}, 12'h000);
        push_off(k + 24, 2);
        step(2);
        sys_reset = 1'b0; k = cyc;
        push_frame(k + 1, 40, 8'h80, 8'hF8, 8'h82, 8'h92);
        step(40);

        step(3);
        check("drain", cyc, 12'(q.size()), 12'h000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
